decoder3_8_strobe: RTL
======================

# decoder3_8_strobe

Registered 3-to-8 decoder and strobe generator: the receive-side counterpart of the 8-to-3 encoder. It accepts a binary code on {x,y,z} through a valid/ready handshake and drives the matching one-hot line of D high for a fixed number of cycles, followed by a fixed idle gap. A one-entry holding register lets the next code be accepted while the current strobe is in progress. The block sits between code-producing control logic and one-hot enable or select lines.

## Interface
Parameters:
- WIDTH, 8, number of one-hot output lines; must satisfy WIDTH <= 2**WIDTH_IN.
- WIDTH_IN, 3, code width; code index = {x,y,z} with x as MSB.
- PULSE_LEN, 4, cycles each strobe is held high; must be >= 1.
- GAP_LEN, 1, cycles of all-zero D between strobes; must be >= 0.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- x  input  1  code bit 2 (MSB).
- y  input  1  code bit 1.
- z  input  1  code bit 0 (LSB).
- in_valid  input  1  code on {x,y,z} is valid.
- in_ready  output  1  holding register empty; a transfer occurs on in_valid && in_ready at a clock edge.
- D  output  WIDTH  registered one-hot strobe; all-zero when no strobe is active.
- busy  output  1  high when state != IDLE or the holding register is full.
- err  output  1  registered one-cycle pulse for an accepted code >= WIDTH.

## Operation
- Holding register (hold_code, hold_full):
  - in_ready = !hold_full; forced 0 while rst_n is low.
  - An accepted code < WIDTH sets hold_full.
  - An accepted code >= WIDTH is discarded, never enters hold, and pulses err at the next edge.
- FSM states IDLE, DRIVE, GAP; down-counter cnt of width $clog2(max(PULSE_LEN,GAP_LEN)+1).
- IDLE:
  - If hold_full: D <= 1<<hold_code, cnt <= PULSE_LEN-1, clear hold_full, go to DRIVE.
  - Otherwise D stays 0.
- DRIVE:
  - While cnt != 0: decrement cnt; D is held.
  - On cnt == 0 with GAP_LEN > 0: D <= 0, cnt <= GAP_LEN-1, go to GAP.
  - On cnt == 0 with GAP_LEN == 0 and hold_full: load the next code directly and stay in DRIVE (back-to-back strobes).
  - On cnt == 0 with GAP_LEN == 0 and hold empty: D <= 0, go to IDLE.
- GAP:
  - While cnt != 0: decrement cnt.
  - On cnt == 0: if hold_full, load as from IDLE and go to DRIVE; else go to IDLE.
- Load and accept in the same cycle: when the FSM loads from hold, hold_full clears at that edge. in_ready rises one cycle later; in_ready does not bypass.
- Reset: the FSM returns to IDLE from any state, including mid-strobe. D, err, cnt, and hold_full clear, and the held code is lost.
- busy = (state != IDLE) || hold_full.

## Timing
- Reset values: D = 0, err = 0, busy = 0, in_ready = 0 during reset and 1 on the first cycle after reset.
- Latency: a transfer at edge N fills hold. The FSM loads at edge N+1, so D is one-hot for cycles N+1 through N+PULSE_LEN.
- err asserts at edge N+1 after the bad transfer, for exactly 1 cycle.
- Strobe period with hold always full: PULSE_LEN + GAP_LEN cycles. D is all-zero for exactly GAP_LEN cycles between strobes.
- A code accepted during DRIVE or GAP waits in hold; further in_valid stalls until hold drains.
- D is never multi-hot. During any load, D switches from 0 or from the old one-hot value to the new one-hot value at a single edge.

## Structure
- Package decoder_pkg:
  - typedef enum for state_t (IDLE, DRIVE, GAP).
  - Localparam helpers for the counter width.
- Sub-module onehot_dec: parameterised combinational index-to-one-hot function (WIDTH_IN to WIDTH), driving the D register input.
- Elaboration-time assertions: PULSE_LEN >= 1 and WIDTH <= 2**WIDTH_IN.

## Test plan
All scenarios use defaults (PULSE_LEN 4, GAP_LEN 1) unless stated.
- Reset then idle: D = 0, busy = 0, in_ready = 1, and they hold for 10 cycles with in_valid = 0.
- Single code {x,y,z} = 3'b101 accepted at edge N -> D = 8'h20 for cycles N+1 to N+4, then D = 0, busy = 0 from N+6.
- Back-to-back codes 0, 7, 2 with in_valid held high -> D = 01,01,01,01,00,80,80,80,80,00,04 (x4). in_ready is low while hold is full.
- GAP_LEN = 0, codes 1 then 6 -> D = 02 (x4) then immediately 40 (x4), with no zero cycle between.
- WIDTH = 6, code 7 accepted -> err pulses exactly 1 cycle, D stays 0, and the next code 4 gives D = 6'h10.
- rst_n low mid-strobe (second DRIVE cycle) with hold full -> D = 0 and busy = 0 at the next edge; the held code never appears on D.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the registered 3-to-8 decoder / strobe generator.
//   state_t        : strobe FSM states (IDLE, DRIVE, GAP)
//   max2           : larger of two integers
//   cnt_width      : width of the shared pulse/gap down-counter
//   code_in_range  : true when an accepted code selects an existing output line
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One counter serves both phases, so it must hold the larger reload value.
    function automatic int cnt_width(input int pulse_len, input int gap_len);
        return $clog2(max2(pulse_len, gap_len) + 1);
    endfunction

    function automatic bit code_in_range(input int code, input int width);
        return (code < width);
    endfunction

endpackage

// File: rtl/decoder3_8_strobe_if.sv
// Code input handshake of decoder3_8_strobe.
//   x, y, z   : code bits, x is the MSB
//   in_valid  : code on {x,y,z} is valid
//   in_ready  : decoder can take a code this cycle
// master = code producer, slave = decoder.
interface decoder3_8_strobe_if;
    logic x;
    logic y;
    logic z;
    logic in_valid;
    logic in_ready;

    modport master (output x, output y, output z, output in_valid, input in_ready);
    modport slave  (input x, input y, input z, input in_valid, output in_ready);
endinterface

// File: rtl/decoder3_8_strobe_chk.sv
// Elaboration-time parameter checks for decoder3_8_strobe. No ports; it only
// stops elaboration when the parameter set cannot work.
module decoder3_8_strobe_chk #(
    parameter int WIDTH     = 8,
    parameter int WIDTH_IN  = 3,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) ();

    if (PULSE_LEN < 1) begin : g_bad_pulse
        $error("decoder3_8_strobe: PULSE_LEN must be >= 1");
    end

    if (GAP_LEN < 0) begin : g_bad_gap
        $error("decoder3_8_strobe: GAP_LEN must be >= 0");
    end

    if (WIDTH > (2 ** WIDTH_IN)) begin : g_bad_width
        $error("decoder3_8_strobe: WIDTH must not exceed 2**WIDTH_IN");
    end

endmodule

// File: rtl/decoder3_8_strobe_onehot_dec.sv
// Combinational index-to-one-hot decoder.
//   idx    : WIDTH_IN-bit binary index
//   onehot : WIDTH lines, bit idx set; all-zero when idx >= WIDTH
module onehot_dec #(
    parameter int WIDTH_IN = 3,
    parameter int WIDTH    = 8
) (
    input  logic [WIDTH_IN-1:0] idx,
    output logic [WIDTH-1:0]    onehot
);

    // Compare the index against every line position.
    always_comb begin
        onehot = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            onehot[i] = (idx == WIDTH_IN'(i));
        end
    end

endmodule

// File: rtl/decoder3_8_strobe.sv
// Registered 3-to-8 decoder and strobe generator.
// A code taken on the bus handshake waits in a one-entry holding register,
// then drives its one-hot line of D for PULSE_LEN cycles followed by GAP_LEN
// all-zero cycles. Codes >= WIDTH are dropped and flagged on err.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : code handshake (x, y, z, in_valid, in_ready)
//   D      : registered one-hot strobe
//   busy   : FSM active or holding register full
//   err    : one-cycle pulse after an out-of-range code is accepted
module decoder3_8_strobe #(
    parameter int WIDTH     = 8,
    parameter int WIDTH_IN  = 3,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    decoder3_8_strobe_if.slave    bus,
    output logic [WIDTH-1:0]      D,
    output logic                  busy,
    output logic                  err
);
    import decoder_pkg::*;

    localparam int               CNT_W      = cnt_width(PULSE_LEN, GAP_LEN);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);
    localparam logic             HAS_GAP    = (GAP_LEN > 0) ? 1'b1 : 1'b0;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [WIDTH-1:0]      d_r;
    logic [WIDTH-1:0]      d_nxt_s;
    logic [WIDTH-1:0]      dec_s;
    logic                  hold_full_r;
    logic                  hold_full_nxt_s;
    logic [WIDTH_IN-1:0]   hold_code_r;
    logic [WIDTH_IN-1:0]   hold_code_nxt_s;
    logic                  err_r;
    logic                  busy_r;
    logic [WIDTH_IN-1:0]   code_s;
    logic                  code_ok_s;
    logic                  accept_s;
    logic                  load_s;
    logic                  cnt_zero_s;

    decoder3_8_strobe_chk #(
        .WIDTH     (WIDTH),
        .WIDTH_IN  (WIDTH_IN),
        .PULSE_LEN (PULSE_LEN),
        .GAP_LEN   (GAP_LEN)
    ) u_chk ();

    onehot_dec #(
        .WIDTH_IN (WIDTH_IN),
        .WIDTH    (WIDTH)
    ) u_dec (
        .idx    (hold_code_r),
        .onehot (dec_s)
    );

    // No bypass: a slot freed by a load is offered only from the next cycle.
    assign bus.in_ready = rst_n & ~hold_full_r;
    assign code_s       = WIDTH_IN'({bus.x, bus.y, bus.z});
    assign code_ok_s    = code_in_range(int'(code_s), WIDTH);
    assign accept_s     = bus.in_valid & bus.in_ready;
    assign cnt_zero_s   = (cnt_r == {CNT_W{1'b0}});

    assign D    = d_r;
    assign busy = busy_r;
    assign err  = err_r;

    // Decide whether the held code starts a strobe at this edge.
    always_comb begin
        load_s = 1'b0;
        if (hold_full_r) begin
            case (state_r)
                IDLE:    load_s = 1'b1;
                DRIVE:   load_s = cnt_zero_s & ~HAS_GAP;
                GAP:     load_s = cnt_zero_s;
                default: load_s = 1'b0;
            endcase
        end else begin
            load_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_s) state_nxt_s = DRIVE;
                else        state_nxt_s = IDLE;
            end
            DRIVE: begin
                if (!cnt_zero_s)  state_nxt_s = DRIVE;
                else if (HAS_GAP) state_nxt_s = GAP;
                else if (load_s)  state_nxt_s = DRIVE;
                else              state_nxt_s = IDLE;
            end
            GAP: begin
                if (!cnt_zero_s) state_nxt_s = GAP;
                else if (load_s) state_nxt_s = DRIVE;
                else             state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: next strobe value and counter.
    always_comb begin
        d_nxt_s   = d_r;
        cnt_nxt_s = cnt_r;
        if (load_s) begin
            // Old one-hot (or zero) replaced by the new one-hot in one edge.
            d_nxt_s   = dec_s;
            cnt_nxt_s = PULSE_LOAD;
        end else begin
            case (state_r)
                IDLE: begin
                    d_nxt_s   = {WIDTH{1'b0}};
                    cnt_nxt_s = {CNT_W{1'b0}};
                end
                DRIVE: begin
                    if (!cnt_zero_s) begin
                        cnt_nxt_s = cnt_r - CNT_W'(1);
                    end else begin
                        d_nxt_s   = {WIDTH{1'b0}};
                        cnt_nxt_s = GAP_LOAD;
                    end
                end
                GAP: begin
                    d_nxt_s = {WIDTH{1'b0}};
                    if (!cnt_zero_s) cnt_nxt_s = cnt_r - CNT_W'(1);
                    else             cnt_nxt_s = {CNT_W{1'b0}};
                end
                default: begin
                    d_nxt_s   = {WIDTH{1'b0}};
                    cnt_nxt_s = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Holding register: fill on a good accept, drain on load (never both).
    always_comb begin
        hold_full_nxt_s = hold_full_r;
        hold_code_nxt_s = hold_code_r;
        if (accept_s && code_ok_s) begin
            hold_full_nxt_s = 1'b1;
            hold_code_nxt_s = code_s;
        end else if (load_s) begin
            hold_full_nxt_s = 1'b0;
        end else begin
            hold_full_nxt_s = hold_full_r;
        end
    end

    // Datapath registers; busy is registered from next-cycle state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_r         <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            hold_full_r <= 1'b0;
            hold_code_r <= {WIDTH_IN{1'b0}};
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            d_r         <= d_nxt_s;
            cnt_r       <= cnt_nxt_s;
            hold_full_r <= hold_full_nxt_s;
            hold_code_r <= hold_code_nxt_s;
            err_r       <= accept_s & ~code_ok_s;
            busy_r      <= (state_nxt_s != IDLE) | hold_full_nxt_s;
        end
    end

endmodule
